// File: rtl/game_tick_scheduler_pkg.sv
// game_tick_scheduler_pkg: shared state encoding, widths and step-period arithmetic.
package game_tick_scheduler_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;
  localparam int STEP_CNT_W = 16;
  localparam int PERIOD_W = 20;
  function automatic logic [PERIOD_W-1:0] calc_period(
    input logic [PERIOD_W-1:0] base,
    input logic [PERIOD_W-1:0] dec,
    input logic [PERIOD_W-1:0] floor,
    input logic [PERIOD_W-1:0] level
  );
    logic [PERIOD_W-1:0] cut;
    cut = level * dec;
    return (cut > base || base - cut < floor) ? floor : base - cut;
  endfunction
endpackage

// File: rtl/game_tick_scheduler_if.sv
// game_tick_scheduler_if: control pulses in, tick/step/status out.
interface game_tick_scheduler_if
  import game_tick_scheduler_pkg::*;
#(
  parameter int LEVEL_W = 4
) ();
  logic tick;
  logic start;
  logic pause_toggle;
  logic game_over;
  logic level_up;
  logic step_ready;
  logic scan_tick;
  logic sample_tick;
  logic step_valid;
  logic [LEVEL_W-1:0] level;
  state_t state;
  logic overrun;
  modport slave (
    input  tick, start, pause_toggle, game_over, level_up, step_ready,
    output scan_tick, sample_tick, step_valid, level, state, overrun
  );
  modport master (
    output tick, start, pause_toggle, game_over, level_up, step_ready,
    input  scan_tick, sample_tick, step_valid, level, state, overrun
  );
endinterface

// File: rtl/game_tick_scheduler_tick_divider.sv
// tick_divider: registered pulse one cycle after every DIV-th enable pulse.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pulse
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= en && cnt == LAST;
      if (en) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: divides the base tick into scan/sample ticks and runs the game-step FSM.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int SAMPLE_DIV = 100,
  parameter int STEP_BASE = 8000,
  parameter int STEP_DEC = 500,
  parameter int STEP_MIN = 1000,
  parameter int LEVEL_W = 4
) (
  input logic clk,
  input logic rst,
  game_tick_scheduler_if.slave bus
);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  state_t state_q, state_d;
  logic [STEP_CNT_W-1:0] cnt_q;
  logic [LEVEL_W-1:0] level_q;
  logic valid_q, overrun_q;
  logic [PERIOD_W-1:0] period;
  logic restart, going_over, due, accept, running;
  tick_divider #(.DIV(SCAN_DIV)) u_scan (
    .clk(clk), .rst(rst), .en(bus.tick), .pulse(bus.scan_tick)
  );
  tick_divider #(.DIV(SAMPLE_DIV)) u_sample (
    .clk(clk), .rst(rst), .en(bus.tick), .pulse(bus.sample_tick)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = bus.start ? RUN : IDLE;
      RUN:   state_d = bus.game_over ? OVER : bus.pause_toggle ? PAUSE : RUN;
      PAUSE: state_d = bus.game_over ? OVER : bus.pause_toggle ? RUN : PAUSE;
      OVER:  state_d = bus.start ? RUN : OVER;
    endcase
  end
  assign period = calc_period(PERIOD_W'(STEP_BASE), PERIOD_W'(STEP_DEC),
                              PERIOD_W'(STEP_MIN), PERIOD_W'(level_q));
  assign running = state_q == RUN;
  assign restart = state_d == RUN && (state_q == IDLE || state_q == OVER);
  assign going_over = state_d == OVER && state_q != OVER;
  // >= rather than == so a period shrunk below the count fires on the next tick
  assign due = running && bus.tick && PERIOD_W'(cnt_q) >= period - PERIOD_W'(1);
  assign accept = valid_q && bus.step_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= (restart || due) ? '0 : (running && bus.tick) ? cnt_q + 1'b1 : cnt_q;
      level_q <= restart ? '0 :
                 (running && bus.level_up && level_q != LEVEL_MAX) ? level_q + 1'b1 : level_q;
      valid_q <= going_over ? 1'b0 : due ? 1'b1 : accept ? 1'b0 : valid_q;
      overrun_q <= restart ? 1'b0 : (due && valid_q && !accept) ? 1'b1 : overrun_q;
    end
  end
  assign bus.state = state_q;
  assign bus.level = level_q;
  assign bus.step_valid = valid_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: directed checks of dividers, step handshake, pause, clamp and restart.
module tb_game_tick_scheduler;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [11:0] scan_m, samp_m;
  logic [15:0] step_m;
  logic any_valid;
  int n;
  always #5 clk = ~clk;
  game_tick_scheduler_if #(.LEVEL_W(4)) ia ();
  game_tick_scheduler_if #(.LEVEL_W(4)) ib ();
  game_tick_scheduler #(
    .SCAN_DIV(4), .SAMPLE_DIV(3), .STEP_BASE(8), .STEP_DEC(2), .STEP_MIN(2), .LEVEL_W(4)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia));
  game_tick_scheduler #(
    .SCAN_DIV(4), .SAMPLE_DIV(100), .STEP_BASE(8000), .STEP_DEC(500), .STEP_MIN(1000), .LEVEL_W(4)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    {ia.tick, ia.start, ia.pause_toggle, ia.game_over, ia.level_up, ia.step_ready} = '0;
    {ib.tick, ib.start, ib.pause_toggle, ib.game_over, ib.level_up, ib.step_ready} = '0;
    rst = 1'b1;
    cyc(2);
    chk("rst_state", ia.state, 0);
    chk("rst_level", ia.level, 0);
    chk("rst_valid", ia.step_valid, 0);
    chk("rst_overrun", ia.overrun, 0);
    chk("rst_scan", ia.scan_tick, 0);
    chk("rst_sample", ia.sample_tick, 0);
    chk("rst_b_state", ib.state, 0);
    rst = 1'b0;
    cyc(1);
    ia.tick = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      scan_m[i] = ia.scan_tick;
      samp_m[i] = ia.sample_tick;
    end
    ia.tick = 1'b0;
    chk("scan_pattern", scan_m, 12'h888);
    chk("sample_pattern", samp_m, 12'h924);
    chk("idle_state", ia.state, 0);
    chk("idle_no_step", ia.step_valid, 0);
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    chk("start_run", ia.state, 1);
    ia.step_ready = 1'b1;
    ia.tick = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      step_m[i] = ia.step_valid;
    end
    ia.tick = 1'b0;
    chk("basic_step_pattern", step_m, 16'h8080);
    cyc(1);
    chk("basic_accept", ia.step_valid, 0);
    ia.step_ready = 1'b0;
    ia.tick = 1'b1;
    cyc(8);
    chk("bp_first_valid", ia.step_valid, 1);
    chk("bp_no_overrun_yet", ia.overrun, 0);
    cyc(8);
    ia.tick = 1'b0;
    chk("bp_held_valid", ia.step_valid, 1);
    chk("bp_overrun", ia.overrun, 1);
    ia.step_ready = 1'b1;
    cyc(1);
    chk("bp_one_accept", ia.step_valid, 0);
    cyc(3);
    chk("bp_no_second_event", ia.step_valid, 0);
    chk("bp_overrun_sticky", ia.overrun, 1);
    ia.tick = 1'b1;
    cyc(5);
    ia.tick = 1'b0;
    chk("pre_pause_no_step", ia.step_valid, 0);
    ia.pause_toggle = 1'b1; cyc(1); ia.pause_toggle = 1'b0;
    chk("pause_state", ia.state, 2);
    ia.tick = 1'b1;
    any_valid = 1'b0;
    repeat (20) begin
      cyc(1);
      any_valid |= ia.step_valid;
    end
    ia.tick = 1'b0;
    chk("pause_no_step", any_valid, 0);
    chk("pause_held", ia.state, 2);
    ia.pause_toggle = 1'b1; cyc(1); ia.pause_toggle = 1'b0;
    chk("resume_state", ia.state, 1);
    ia.tick = 1'b1;
    cyc(1);
    chk("resume_tick1", ia.step_valid, 0);
    cyc(1);
    chk("resume_tick2", ia.step_valid, 0);
    cyc(1);
    ia.tick = 1'b0;
    ia.step_ready = 1'b0;
    chk("resume_tick3_step", ia.step_valid, 1);
    ia.level_up = 1'b1; cyc(1); ia.level_up = 1'b0;
    chk("level_up", ia.level, 1);
    chk("valid_before_over", ia.step_valid, 1);
    ia.game_over = 1'b1; ia.pause_toggle = 1'b1; cyc(1);
    ia.game_over = 1'b0; ia.pause_toggle = 1'b0;
    chk("over_priority", ia.state, 3);
    chk("over_clears_valid", ia.step_valid, 0);
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    chk("restart_state", ia.state, 1);
    chk("restart_level", ia.level, 0);
    chk("restart_overrun", ia.overrun, 0);
    ia.level_up = 1'b1; cyc(1); ia.level_up = 1'b0;
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    chk("start_ignored_state", ia.state, 1);
    chk("start_ignored_level", ia.level, 1);
    ia.tick = 1'b1;
    cyc(5);
    chk("lvl1_not_yet", ia.step_valid, 0);
    cyc(1);
    ia.tick = 1'b0;
    chk("lvl1_period6", ia.step_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", ia.state, 0);
    chk("async_rst_valid", ia.step_valid, 0);
    chk("async_rst_level", ia.level, 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    ib.start = 1'b1; cyc(1); ib.start = 1'b0;
    chk("b_run", ib.state, 1);
    repeat (20) begin
      ib.level_up = 1'b1; cyc(1);
      ib.level_up = 1'b0; cyc(1);
    end
    chk("clamp_level", ib.level, 15);
    ib.step_ready = 1'b1;
    ib.tick = 1'b1;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!ib.step_valid && n < 3000);
    chk("clamp_first_interval", n, 1000);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!ib.step_valid && n < 3000);
    ib.tick = 1'b0;
    chk("clamp_second_interval", n, 1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
